branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 174 +++++++++++++++++
 tb/tb_branch_predictor.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direction predictor built from a table of 2^IDX_W two-bit saturating
// counters (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
//
// Prediction is purely combinational: the fetch PC selects a counter and
// its MSB is the predicted direction. Resolving branches hand back the
// index they were predicted with and train that counter on the clock edge.
// A registered flush pulse and a saturating 16-bit miss counter report
// direction mispredictions.
//
// Optional feature: define BRANCH_PREDICTOR_GSHARE_EN to XOR the PC index
// with an IDX_W-bit global history register (gshare). Without the macro the
// table is indexed by PC bits only and no history register exists.
//
// Ports
//   clk_i         in   1      clock, all state changes on rising edge
//   rst_i         in   1      asynchronous active-high reset
//   Pred_valid_i  in   1      fetch requests a prediction this cycle
//   Pred_pc_i     in   32     PC of the fetched instruction
//   Pred_taken_o  out  1      predicted direction (1 = taken)
//   Pred_idx_o    out  IDX_W  table index used for this prediction
//   Upd_valid_i   in   1      a conditional branch resolved this cycle
//   Upd_idx_i     in   IDX_W  index carried back by the resolving branch
//   Upd_taken_i   in   1      actual branch outcome
//   Upd_pred_i    in   1      direction that was predicted for that branch
//   Mispredict_o  out  1      registered flush request, one cycle per miss
//   Miss_cnt_o    out  16     saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             Pred_valid_i,
    input  logic [31:0]      Pred_pc_i,
    output logic             Pred_taken_o,
    output logic [IDX_W-1:0] Pred_idx_o,
    input  logic             Upd_valid_i,
    input  logic [IDX_W-1:0] Upd_idx_i,
    input  logic             Upd_taken_i,
    input  logic             Upd_pred_i,
    output logic             Mispredict_o,
    output logic [15:0]      Miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;

    // Counter encodings
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    localparam logic [15:0] MISS_MAX = 16'hFFFF;

    // -------------------------------------------------------------------------
    // Prediction index
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] pred_idx;

    // Instructions are word aligned, so the two LSBs carry no information.
    assign pc_idx = Pred_pc_i[IDX_W+1:2];

    // PC bits outside the index window are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{Pred_pc_i[31:IDX_W+2], Pred_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    // Global history of resolved outcomes, newest outcome in bit 0.
    logic [IDX_W-1:0] ghr_reg;
    logic [IDX_W-1:0] ghr_next;

    always_comb begin
        ghr_next = ghr_reg;
        if (Upd_valid_i) begin
            ghr_next = {ghr_reg[IDX_W-2:0], Upd_taken_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
        end
    end

    // A prediction in the same cycle as an update sees the old history,
    // because ghr_reg only moves on the edge.
    assign pred_idx = pc_idx ^ ghr_reg;
`else
    assign pred_idx = pc_idx;
`endif

    // -------------------------------------------------------------------------
    // Counter table
    //
    // Every counter has to snap to weak-NT asynchronously on reset, so the
    // table is a bank of flops rather than a RAM. Each entry owns its own
    // register and update logic; the packed view ctr_vec is the read port.
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0][1:0] ctr_vec;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
        logic [1:0] ctr_reg;
        logic [1:0] ctr_next;
        logic       hit;

        assign hit = Upd_valid_i && (Upd_idx_i == IDX_W'(gi));

        always_comb begin
            ctr_next = ctr_reg;
            if (hit) begin
                if (Upd_taken_i) begin
                    if (ctr_reg != CTR_STRONG_T) begin
                        ctr_next = ctr_reg + 2'd1;
                    end
                end else begin
                    if (ctr_reg != CTR_STRONG_NT) begin
                        ctr_next = ctr_reg - 2'd1;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ctr_reg <= CTR_WEAK_NT;
            end else begin
                ctr_reg <= ctr_next;
            end
        end

        assign ctr_vec[gi] = ctr_reg;
    end

    // Read is from the registered table, so a same-cycle update to the same
    // entry is not visible until the following cycle.
    assign Pred_idx_o   = pred_idx;
    assign Pred_taken_o = Pred_valid_i & ctr_vec[pred_idx][1];

    // -------------------------------------------------------------------------
    // Misprediction reporting
    // -------------------------------------------------------------------------
    logic        miss_event;
    logic        mispredict_reg;
    logic [15:0] miss_cnt_reg;
    logic [15:0] miss_cnt_next;

    assign miss_event = Upd_valid_i & (Upd_taken_i ^ Upd_pred_i);

    always_comb begin
        miss_cnt_next = miss_cnt_reg;
        if (miss_event && (miss_cnt_reg != MISS_MAX)) begin
            miss_cnt_next = miss_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mispredict_reg <= 1'b0;
            miss_cnt_reg   <= '0;
        end else begin
            mispredict_reg <= miss_event;
            miss_cnt_reg   <= miss_cnt_next;
        end
    end

    assign Mispredict_o = mispredict_reg;
    assign Miss_cnt_o   = miss_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. A behavioural model (integer
// counter table, integer miss count, integer history) predicts every output;
// directed scenarios cover reset, training, saturation, same-cycle
// read/update, mid-run reset and miss-counter saturation, plus a randomized
// run. Build with +define+BRANCH_PREDICTOR_GSHARE_EN to exercise gshare.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int IDX_W   = 6;
    localparam int ENTRIES = 1 << IDX_W;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             Pred_valid_i = 1'b0;
    logic [31:0]      Pred_pc_i = '0;
    logic             Pred_taken_o;
    logic [IDX_W-1:0] Pred_idx_o;
    logic             Upd_valid_i = 1'b0;
    logic [IDX_W-1:0] Upd_idx_i = '0;
    logic             Upd_taken_i = 1'b0;
    logic             Upd_pred_i = 1'b0;
    logic             Mispredict_o;
    logic [15:0]      Miss_cnt_o;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .Pred_valid_i (Pred_valid_i),
        .Pred_pc_i    (Pred_pc_i),
        .Pred_taken_o (Pred_taken_o),
        .Pred_idx_o   (Pred_idx_o),
        .Upd_valid_i  (Upd_valid_i),
        .Upd_idx_i    (Upd_idx_i),
        .Upd_taken_i  (Upd_taken_i),
        .Upd_pred_i   (Upd_pred_i),
        .Mispredict_o (Mispredict_o),
        .Miss_cnt_o   (Miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // ---------------- reference model ----------------
    int m_ctr [ENTRIES];   // 0..3 counter strength
    int m_miss;
    int m_misp;
    int m_ghr;

    // observations and expectations from the last drive() call
    logic             obs_taken;
    logic [IDX_W-1:0] obs_idx;
    logic             obs_misp;
    logic [15:0]      obs_miss;
    int               exp_taken;
    int               exp_idx;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_miss = 0;
        m_misp = 0;
        m_ghr  = 0;
    endfunction

    function automatic int model_idx(input logic [31:0] pc);
        int base;
        base = int'(pc / 4) % ENTRIES;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return base ^ m_ghr;
`else
        return base;
`endif
    endfunction

    function automatic void model_update(input bit uv, input int uidx, input bit ut, input bit up);
        if (uv) begin
            if (ut) m_ctr[uidx] = (m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3;
            else    m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            m_ghr = (m_ghr * 2 + int'(ut)) % ENTRIES;
`endif
        end
        m_misp = (uv && (ut != up)) ? 1 : 0;
        if (m_misp == 1 && m_miss < 65535) m_miss = m_miss + 1;
    endfunction

    // One transaction: drive at negedge, sample combinational outputs, step
    // the model at posedge, sample registered outputs just after it.
    task automatic drive(input bit pv, input logic [31:0] pc, input bit uv,
                         input int uidx, input bit ut, input bit up);
        @(negedge clk_i);
        Pred_valid_i = pv;
        Pred_pc_i    = pc;
        Upd_valid_i  = uv;
        Upd_idx_i    = IDX_W'(uidx);
        Upd_taken_i  = ut;
        Upd_pred_i   = up;
        #1;
        obs_taken = Pred_taken_o;
        obs_idx   = Pred_idx_o;
        exp_idx   = model_idx(pc);
        exp_taken = (pv && m_ctr[exp_idx] >= 2) ? 1 : 0;
        @(posedge clk_i);
        model_update(uv, uidx, ut, up);
        #1;
        Pred_valid_i = 1'b0;
        Upd_valid_i  = 1'b0;
        obs_misp = Mispredict_o;
        obs_miss = Miss_cnt_o;
        if (verbose)
            $display("txn t=%0t pv=%0d pc=%h uv=%0d uidx=%0d ut=%0d up=%0d -> taken=%0d idx=%0d misp=%0d miss=%0d",
                     $time, pv, pc, uv, uidx, ut, up, obs_taken, obs_idx, obs_misp, obs_miss);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        Pred_valid_i = 1'b0;
        Upd_valid_i  = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (Mispredict_o !== 1'b0 || Miss_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: misp=%0d miss=%0d required 0/0", Mispredict_o, Miss_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        drive(1'b1, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_idx !== 6'd16) begin
            errors++;
            $display("FAIL reset_idx40: got %0d required 16", obs_idx);
        end
        checks++;
        if (obs_taken !== 1'b0 || obs_miss !== 16'd0) begin
            errors++;
            $display("FAIL reset_pred40: taken=%0d miss=%0d required 0/0", obs_taken, obs_miss);
        end
        // every entry must read weak-NT (not taken)
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (obs_taken !== 1'b0 || int'(obs_idx) != exp_idx) begin
                errors++;
                $display("FAIL reset_scan[%0d]: taken=%0d idx=%0d required 0 idx=%0d", i, obs_taken, obs_idx, exp_idx);
            end
        end
    endtask

    task automatic test_train_taken();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 1'b1, 16, 1'b1, 1'b0);
            checks++;
            if (obs_misp !== 1'b1 || int'(obs_miss) != m_miss) begin
                errors++;
                $display("FAIL train_misp[%0d]: misp=%0d miss=%0d required 1 miss=%0d", k, obs_misp, obs_miss, m_miss);
            end
        end
        drive(1'b1, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (int'(obs_taken) != exp_taken || int'(obs_idx) != exp_idx) begin
            errors++;
            $display("FAIL train_pred: taken=%0d idx=%0d required %0d idx=%0d", obs_taken, obs_idx, exp_taken, exp_idx);
        end
        checks++;
        if (obs_misp !== 1'b0 || int'(obs_miss) != m_miss) begin
            errors++;
            $display("FAIL train_cnt: misp=%0d miss=%0d required 0 miss=%0d", obs_misp, obs_miss, m_miss);
        end
    endtask

    task automatic test_saturate_down();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 1'b1, 16, 1'b0, 1'b0);
            checks++;
            if (obs_misp !== 1'b0) begin
                errors++;
                $display("FAIL satdown_misp[%0d]: got %0d required 0", k, obs_misp);
            end
        end
        // reach entry 16 regardless of history by choosing the PC
        drive(1'b1, 32'((16 ^ (m_ghr)) * 4), 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (int'(obs_taken) != exp_taken || obs_taken !== 1'b0) begin
            errors++;
            $display("FAIL satdown_pred: taken=%0d required 0", obs_taken);
        end
        // one increment from 00 must still predict not-taken
        drive(1'b0, 32'h0, 1'b1, 16, 1'b1, 1'b1);
        drive(1'b1, 32'((16 ^ (m_ghr)) * 4), 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_taken !== 1'b0 || int'(obs_idx) != 16) begin
            errors++;
            $display("FAIL satdown_floor: taken=%0d idx=%0d required 0 idx=16", obs_taken, obs_idx);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1'b1, 32'h0000_0040, 1'b1, 16, 1'b1, 1'b1);
        checks++;
        if (int'(obs_taken) != exp_taken || obs_taken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_old: taken=%0d required 0", obs_taken);
        end
        drive(1'b1, 32'((16 ^ m_ghr) * 4), 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_taken !== 1'b1 || int'(obs_taken) != exp_taken) begin
            errors++;
            $display("FAIL same_cycle_new: taken=%0d required 1", obs_taken);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit pv, uv, ut, up;
            logic [31:0] pc;
            int uidx;
            pv   = 1'($urandom);
            uv   = 1'($urandom);
            ut   = 1'($urandom);
            up   = 1'($urandom);
            pc   = $urandom;
            uidx = int'($urandom_range(0, 7)) * 8 + int'($urandom_range(0, 1));
            pc[IDX_W+1:2] = IDX_W'($urandom_range(0, 7) * 8 + $urandom_range(0, 1));
            drive(pv, pc, uv, uidx, ut, up);
            checks++;
            if (int'(obs_taken) != exp_taken || int'(obs_idx) != exp_idx) begin
                errors++;
                $display("FAIL rand_pred[%0d]: taken=%0d idx=%0d required %0d idx=%0d", i, obs_taken, obs_idx, exp_taken, exp_idx);
            end
            checks++;
            if (int'(obs_misp) != m_misp || int'(obs_miss) != m_miss) begin
                errors++;
                $display("FAIL rand_miss[%0d]: misp=%0d miss=%0d required %0d miss=%0d", i, obs_misp, obs_miss, m_misp, m_miss);
            end
        end
    endtask

    task automatic test_mid_reset();
        // leave history and counters in a non-reset state
        drive(1'b0, 32'h0, 1'b1, 16, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 16, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 5, 1'b0, 1'b1);
        @(negedge clk_i);
        Pred_valid_i = 1'b1;
        Pred_pc_i    = 32'h0000_0040;
        Upd_valid_i  = 1'b1;
        Upd_idx_i    = 6'd16;
        Upd_taken_i  = 1'b1;
        Upd_pred_i   = 1'b0;
        #1;
        rst_i = 1'b1;
        #1;
        model_reset();
        checks++;
        if (Mispredict_o !== 1'b0 || Miss_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL midrst_async: misp=%0d miss=%0d required 0/0", Mispredict_o, Miss_cnt_o);
        end
        checks++;
        if (Pred_idx_o !== 6'd16 || Pred_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_table: idx=%0d taken=%0d required 16/0", Pred_idx_o, Pred_taken_o);
        end
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        rst_i = 1'b0;
        Upd_valid_i  = 1'b0;
        #1;
        checks++;
        if (Pred_taken_o !== 1'b0 || Pred_idx_o !== 6'd16 || Miss_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL midrst_discard: taken=%0d idx=%0d miss=%0d required 0/16/0", Pred_taken_o, Pred_idx_o, Miss_cnt_o);
        end
        // first edge after release must train
        drive(1'b0, 32'h0, 1'b1, 16, 1'b1, 1'b0);
        checks++;
        if (obs_miss !== 16'd1 || obs_misp !== 1'b1) begin
            errors++;
            $display("FAIL midrst_first_edge: misp=%0d miss=%0d required 1/1", obs_misp, obs_miss);
        end
        drive(1'b1, 32'((16 ^ m_ghr) * 4), 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_taken !== 1'b1 || int'(obs_taken) != exp_taken) begin
            errors++;
            $display("FAIL midrst_trained: taken=%0d required 1", obs_taken);
        end
    endtask

    task automatic test_gshare_history();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (int'(obs_idx) != exp_idx) begin
            errors++;
            $display("FAIL hist_idx: got %0d required %0d", obs_idx, exp_idx);
        end
    endtask

    task automatic test_miss_saturate();
        do_reset();
        verbose = 1'b0;
        while (m_miss < 16'hFFFE) begin
            bit ut;
            ut = 1'($urandom);
            drive(1'b0, 32'h0, 1'b1, int'($urandom_range(0, ENTRIES - 1)), ut, ~ut);
        end
        verbose = 1'b1;
        checks++;
        if (obs_miss !== 16'hFFFE || obs_misp !== 1'b1) begin
            errors++;
            $display("FAIL miss_preload: miss=%h misp=%0d required fffe/1", obs_miss, obs_misp);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 7, 1'b0, 1'b1);
            checks++;
            if (obs_miss !== 16'hFFFF || int'(obs_miss) != m_miss) begin
                errors++;
                $display("FAIL miss_sat[%0d]: got %h required ffff", k, obs_miss);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 7, 1'b0, 1'b1);
        checks++;
        if (obs_misp !== 1'b0 || obs_miss !== 16'hFFFF) begin
            errors++;
            $display("FAIL miss_hold: misp=%0d miss=%h required 0/ffff", obs_misp, obs_miss);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_train_taken();
        test_saturate_down();
        test_same_cycle();
        test_random();
        test_mid_reset();
        test_gshare_history();
        test_miss_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
